complex_integrate_dump: RTL and testbench
=========================================

# complex_integrate_dump

Streaming complex integrate-and-dump stage that sits directly downstream of the Q0.15 complex multiplier in the receive correlator path. It re-times a sample-valid strobe through the multiplier's fixed pipeline latency. It sums ACC_LEN consecutive valid complex products, then emits one averaged, saturated Q0.15 complex result per window with a single-cycle valid pulse. There is no dead time between windows.

## Interface
- DATAWIDTH, 16 — sample width, Q0.15 two's complement
- FRAC_BITS, 15 — fractional bits of in/out samples
- ACC_LEN, 64 — samples per window; power of two, 2..4096
- MULT_LATENCY, 4 — upstream multiplier latency in clocks, 1..16

- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- in_valid_i  in  1  valid strobe aligned to the multiplier *inputs*
- re_i  in  DATAWIDTH  real product from multiplier (signed)
- im_i  in  DATAWIDTH  imaginary product from multiplier (signed)
- start_i  in  1  pulse: open (or restart) accumulation
- stop_i  in  1  pulse: abandon accumulation, go idle
- re_o  out  DATAWIDTH  window average, real (signed)
- im_o  out  DATAWIDTH  window average, imaginary (signed)
- valid_o  out  1  one-cycle pulse per completed window
- busy_o  out  1  high while in ACC state

## Operation
- LOG2_LEN = log2(ACC_LEN); ACC_W = DATAWIDTH + LOG2_LEN; accumulators are signed ACC_W bits and cannot overflow.
- The delay line shifts in_valid_i by MULT_LATENCY cycles, producing prod_valid. prod_valid is the qualifier for re_i/im_i; re_i/im_i are never delayed internally.
- States:
  - IDLE: accumulators and counter held at 0; products are ignored.
  - ACC: each prod_valid adds re_i/im_i to the accumulators and increments the counter (LOG2_LEN+1 bits).
- Transitions:
  - IDLE→ACC on start_i.
  - ACC→IDLE on stop_i; the partial sum is discarded and no valid_o is generated.
  - start_i in ACC restarts the window: counter and accumulators are cleared.
  - start_i and stop_i asserted together: stop_i wins.
- start edge with prod_valid high: that product is the first sample of the new window (acc ← sample, count ← 1).
- Dump, on the edge of the ACC_LEN-th product:
  - sum = acc + sample; out = sum >>> LOG2_LEN (arithmetic shift).
  - out saturates to [−2^(DATAWIDTH−1), 2^(DATAWIDTH−1)−1].
  - Result is registered into re_o/im_o; acc ← 0; count ← 0; the block stays in ACC.
- re_o/im_o hold their last dumped value until the next dump.
- Reset values: re_o=0, im_o=0, valid_o=0, busy_o=0, state IDLE, counter 0, accumulators 0, delay line all 0.
- Reset mid-window: the window is discarded and in-flight strobes are flushed. After reset, valid_o stays low until a new start_i arrives and a full window completes.

## Timing
- A strobe on in_valid_i at edge t qualifies re_i/im_i at edge t+MULT_LATENCY.
- valid_o is high in the cycle after the edge that captured the ACC_LEN-th product, together with the new re_o/im_o.
- End-to-end: the last input strobe at edge t gives valid_o high during cycle t+MULT_LATENCY+1.
- With continuous valid input, valid_o pulses every ACC_LEN cycles.
- busy_o rises the cycle after start_i and falls the cycle after stop_i.
- No backpressure; the consumer must accept each valid_o pulse.

## Configuration
- CID_ROUND_EN defined: dump computes (sum + 2^(LOG2_LEN−1)) >>> LOG2_LEN, i.e. round-half-up, then saturates.
- CID_ROUND_EN undefined: plain truncation (arithmetic shift toward −∞), then saturates.
- Saturation is always present in both builds.

## Structure
- Shared package rx_dsp_pkg holds:
  - the state enum (IDLE, ACC);
  - the Q0.15 saturation limit constants;
  - a saturate function (ACC_W → DATAWIDTH).
- One sub-module: valid_delay_line (parameter DEPTH, shift register with synchronous active-low clear), instantiated with DEPTH=MULT_LATENCY.

## Test plan
- ACC_LEN=4, MULT_LATENCY=4; start_i, then 4 strobes with products re=16384, im=−16384 → single valid_o pulse at last strobe +5 cycles; re_o=16384, im_o=−16384.
- Continuous strobes with re=32767 for 3 windows → valid_o every 4 cycles; re_o=32767 each window, with no dropped or doubled samples at window boundaries.
- Products re = 1,0,0,0 over one window → re_o=0 when truncating; re_o=0 with CID_ROUND_EN (1/4 < 0.5). Products 2,0,0,0 → 0 when truncating, 1 with CID_ROUND_EN.
- Products re = −1,0,0,0 → re_o=−1 when truncating; re_o=0 with CID_ROUND_EN.
- stop_i after 2 samples, then start_i with 4 samples of 100 → exactly one valid_o, re_o=100; start_i and stop_i in the same cycle → busy_o=0.
- rst_n low for 1 cycle mid-window with strobes still in flight → all outputs 0, no valid_o until a new start_i and full window.

Source files
------------

// File: rtl/rx_dsp_pkg.sv
// Shared receive-DSP types and helpers: integrate/dump state enum, Q0.15 limits, saturation.
// Latency: n/a (package, combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   cid_state_t : IDLE / ACC state of the integrate-and-dump stage
//   Q15_MAX/MIN : Q0.15 saturation limits
//   saturate()  : clamp a wide signed value into a signed dw-bit range
package rx_dsp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } cid_state_t;

  localparam int Q15_W = 16;
  localparam logic signed [Q15_W-1:0] Q15_MAX = 16'sh7fff;
  localparam logic signed [Q15_W-1:0] Q15_MIN = 16'sh8000;

  // Working width for the saturate helper; wide enough for DATAWIDTH + log2(4096) + rounding bit.
  localparam int SAT_IN_W = 32;

  // Clamp x into [-2^(dw-1), 2^(dw-1)-1]. The result stays SAT_IN_W wide;
  // callers truncate to dw bits, which is lossless after clamping.
  function automatic logic signed [SAT_IN_W-1:0] saturate(
    input logic signed [SAT_IN_W-1:0] x,
    input int                         dw
  );
    logic signed [SAT_IN_W-1:0] hi;
    logic signed [SAT_IN_W-1:0] lo;
    if (dw == Q15_W) begin
      hi = SAT_IN_W'(Q15_MAX);
      lo = SAT_IN_W'(Q15_MIN);
    end else begin
      hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
      lo = -hi - 32'sd1;
    end
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift register that re-times a 1-bit strobe by DEPTH clocks.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; every bit is shifted each cycle.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low clear of every stage
//   din   : strobe in
//   dout  : strobe delayed by DEPTH clocks
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst_n) sr <= '0;
        else        sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/complex_integrate_dump.sv
// Complex integrate-and-dump: averages ACC_LEN valid Q0.15 products into one saturated result.
// Latency: valid_o one cycle after the edge capturing the ACC_LEN-th product (strobe + MULT_LATENCY + 1).
// Backpressure: none; the consumer must take every single-cycle valid_o pulse.
//
// Build option: define CID_ROUND_EN for round-half-up averaging; default is truncation (toward -inf).
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid_i          : strobe aligned to the multiplier inputs (delayed internally by MULT_LATENCY)
//   re_i, im_i          : multiplier products, qualified by the delayed strobe
//   start_i, stop_i     : open/restart a window, abandon and go idle (stop wins)
//   re_o, im_o, valid_o : window average and its one-cycle pulse
//   busy_o              : high while accumulating
module complex_integrate_dump
  import rx_dsp_pkg::*;
#(
  parameter int DATAWIDTH    = 16,
  parameter int FRAC_BITS    = 15,
  parameter int ACC_LEN      = 64,
  parameter int MULT_LATENCY = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid_i,
  input  logic signed [DATAWIDTH-1:0] re_i,
  input  logic signed [DATAWIDTH-1:0] im_i,
  input  logic                        start_i,
  input  logic                        stop_i,
  output logic signed [DATAWIDTH-1:0] re_o,
  output logic signed [DATAWIDTH-1:0] im_o,
  output logic                        valid_o,
  output logic                        busy_o
);

  localparam int LOG2_LEN = $clog2(ACC_LEN);
  localparam int ACC_W    = DATAWIDTH + LOG2_LEN;
  localparam int CNT_W    = LOG2_LEN + 1;

  // Averaging keeps the sample format, so the fixed-point layout must be Q0.(DATAWIDTH-1).
  generate
    if (FRAC_BITS != DATAWIDTH - 1) begin : g_bad_format
      $error("complex_integrate_dump: FRAC_BITS must equal DATAWIDTH-1");
    end
    if ((1 << LOG2_LEN) != ACC_LEN) begin : g_bad_len
      $error("complex_integrate_dump: ACC_LEN must be a power of two");
    end
  endgenerate

  logic prod_valid;

  valid_delay_line #(
    .DEPTH (MULT_LATENCY)
  ) u_valid_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (in_valid_i),
    .dout  (prod_valid)
  );

  cid_state_t                 state;
  logic signed [ACC_W-1:0]    acc_re;
  logic signed [ACC_W-1:0]    acc_im;
  logic        [CNT_W-1:0]    cnt;

  // Running sums including the current product; also the dump operand.
  logic signed [SAT_IN_W-1:0] sum_re;
  logic signed [SAT_IN_W-1:0] sum_im;
  logic signed [SAT_IN_W-1:0] avg_re;
  logic signed [SAT_IN_W-1:0] avg_im;
  logic signed [DATAWIDTH-1:0] sat_re;
  logic signed [DATAWIDTH-1:0] sat_im;

  always_comb begin
    sum_re = SAT_IN_W'(acc_re) + SAT_IN_W'(re_i);
    sum_im = SAT_IN_W'(acc_im) + SAT_IN_W'(im_i);
`ifdef CID_ROUND_EN
    // Half an LSB of the output added before the floor shift gives round-half-up.
    avg_re = (sum_re + (32'sd1 <<< (LOG2_LEN - 1))) >>> LOG2_LEN;
    avg_im = (sum_im + (32'sd1 <<< (LOG2_LEN - 1))) >>> LOG2_LEN;
`else
    avg_re = sum_re >>> LOG2_LEN;
    avg_im = sum_im >>> LOG2_LEN;
`endif
    sat_re = DATAWIDTH'(saturate(avg_re, DATAWIDTH));
    sat_im = DATAWIDTH'(saturate(avg_im, DATAWIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy_o  <= 1'b0;
      valid_o <= 1'b0;
      re_o    <= '0;
      im_o    <= '0;
      acc_re  <= '0;
      acc_im  <= '0;
      cnt     <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        IDLE: begin
          acc_re <= '0;
          acc_im <= '0;
          cnt    <= '0;
          if (start_i && !stop_i) begin
            state  <= ACC;
            busy_o <= 1'b1;
            // A product arriving on the start edge opens the new window.
            if (prod_valid) begin
              acc_re <= ACC_W'(re_i);
              acc_im <= ACC_W'(im_i);
              cnt    <= CNT_W'(1);
            end
          end
        end
        ACC: begin
          if (stop_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
          end else if (start_i) begin
            if (prod_valid) begin
              acc_re <= ACC_W'(re_i);
              acc_im <= ACC_W'(im_i);
              cnt    <= CNT_W'(1);
            end else begin
              acc_re <= '0;
              acc_im <= '0;
              cnt    <= '0;
            end
          end else if (prod_valid) begin
            if (cnt == CNT_W'(ACC_LEN - 1)) begin
              // Last product of the window: dump and immediately reopen.
              re_o    <= sat_re;
              im_o    <= sat_im;
              valid_o <= 1'b1;
              acc_re  <= '0;
              acc_im  <= '0;
              cnt     <= '0;
            end else begin
              acc_re <= ACC_W'(sum_re);
              acc_im <= ACC_W'(sum_im);
              cnt    <= cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_complex_integrate_dump.sv
// Testbench for complex_integrate_dump (ACC_LEN=4, MULT_LATENCY=4).
// Latency: n/a.
// Backpressure: n/a.
module tb_complex_integrate_dump;

  localparam int DW  = 16;
  localparam int LEN = 4;
  localparam int ML  = 4;

`ifdef CID_ROUND_EN
  localparam int E_NEG1 = 0;
  localparam int E_TWO  = 1;
`else
  localparam int E_NEG1 = -1;
  localparam int E_TWO  = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid_i;
  logic signed [DW-1:0] re_i;
  logic signed [DW-1:0] im_i;
  logic start_i;
  logic stop_i;
  logic signed [DW-1:0] re_o;
  logic signed [DW-1:0] im_o;
  logic valid_o;
  logic busy_o;

  complex_integrate_dump #(
    .DATAWIDTH    (DW),
    .FRAC_BITS    (DW - 1),
    .ACC_LEN      (LEN),
    .MULT_LATENCY (ML)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .re_i       (re_i),
    .im_i       (im_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .re_o       (re_o),
    .im_o       (im_o),
    .valid_o    (valid_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int vq[$];          // cycle numbers of observed valid_o pulses

  // Behavioural reference: strobe history, window contents as lists of samples.
  bit dlq[$];
  bit m_active;
  int win_re[$];
  int win_im[$];
  int m_re, m_im;
  bit m_valid;

  typedef struct {
    bit st, sp, iv;
    int re, im;
    bit e_busy, e_valid;
    int e_re, e_im;
  } vec_t;
  vec_t tbl[$];
  int prev_re = 0;
  int prev_im = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Window average computed with integer division: floor, optional +half, clamp.
  function automatic int avg(input int q[$]);
    int s;
    int d;
    s = 0;
    foreach (q[i]) s += q[i];
`ifdef CID_ROUND_EN
    s += LEN / 2;
`endif
    d = s / LEN;
    if ((s % LEN != 0) && (s < 0)) d--;
    if (d > 32767)  d = 32767;
    if (d < -32768) d = -32768;
    return d;
  endfunction

  task automatic model_edge(input bit rs, input bit st, input bit sp, input bit iv, input int re, input int im);
    bit pv;
    if (!rs) begin
      dlq.delete();
      repeat (ML) dlq.push_back(1'b0);
      m_active = 0;
      win_re.delete();
      win_im.delete();
      m_re = 0;
      m_im = 0;
      m_valid = 0;
    end else begin
      pv = dlq.pop_front();
      dlq.push_back(iv);
      m_valid = 0;
      if (sp) begin
        m_active = 0;
        win_re.delete();
        win_im.delete();
      end else if (st) begin
        m_active = 1;
        win_re.delete();
        win_im.delete();
        if (pv) begin
          win_re.push_back(re);
          win_im.push_back(im);
        end
      end else if (m_active && pv) begin
        win_re.push_back(re);
        win_im.push_back(im);
        if (win_re.size() == LEN) begin
          m_re = avg(win_re);
          m_im = avg(win_im);
          m_valid = 1;
          win_re.delete();
          win_im.delete();
        end
      end
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit sp, input bit iv, input int re, input int im);
    rst_n      = rs;
    start_i    = st;
    stop_i     = sp;
    in_valid_i = iv;
    re_i       = 16'(re);
    im_i       = 16'(im);
    @(posedge clk);
    model_edge(rs, st, sp, iv, int'(re_i), int'(im_i));
    #1;
    cyc++;
    chk("model_valid", int'(valid_o), int'(m_valid));
    chk("model_busy",  int'(busy_o),  int'(m_active));
    chk("model_re",    int'(re_o),    m_re);
    chk("model_im",    int'(im_o),    m_im);
    if (valid_o) vq.push_back(cyc);
  endtask

  task automatic add(input bit st, input bit sp, input bit iv, input int re, input int im,
                     input bit eb, input bit ev, input int er, input int ei);
    vec_t v;
    v.st = st; v.sp = sp; v.iv = iv; v.re = re; v.im = im;
    v.e_busy = eb; v.e_valid = ev; v.e_re = er; v.e_im = ei;
    tbl.push_back(v);
  endtask

  // One window: 4 strobes, then products (r0,i0),(r1,i1)x3 arriving ML cycles later.
  task automatic add_window(input int r0, input int i0, input int r1, input int i1,
                            input int er, input int ei);
    repeat (LEN) add(0, 0, 1, 0, 0, 1, 0, prev_re, prev_im);
    add(0, 0, 0, r0, i0, 1, 0, prev_re, prev_im);
    repeat (LEN - 2) add(0, 0, 0, r1, i1, 1, 0, prev_re, prev_im);
    add(0, 0, 0, r1, i1, 1, 1, er, ei);
    prev_re = er;
    prev_im = ei;
  endtask

  initial begin
    bit st, sp, iv, rs;
    int r;

    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_re", int'(re_o), 0);
    chk("reset_valid", int'(valid_o), 0);
    chk("reset_busy", int'(busy_o), 0);

    // Directed table
    add(1, 0, 0, 0, 0, 1, 0, 0, 0);
    add_window(16384, -16384, 16384, -16384, 16384, -16384);
    add_window(-1, 0, 0, 0, E_NEG1, 0);
    add_window(2, 0, 0, 0, E_TWO, 0);
    add_window(1, 0, 0, 0, 0, 0);
    add_window(32767, -32768, 32767, -32768, 32767, -32768);
    repeat (ML + 1) add(0, 0, 0, 0, 0, 1, 0, prev_re, prev_im);
    foreach (tbl[i]) begin
      step(1, tbl[i].st, tbl[i].sp, tbl[i].iv, tbl[i].re, tbl[i].im);
      chk("tbl_busy",  int'(busy_o),  int'(tbl[i].e_busy));
      chk("tbl_valid", int'(valid_o), int'(tbl[i].e_valid));
      chk("tbl_re",    int'(re_o),    tbl[i].e_re);
      chk("tbl_im",    int'(im_o),    tbl[i].e_im);
    end

    // Continuous strobes, three back-to-back windows
    vq.delete();
    step(1, 1, 0, 1, 32767, -32768);
    repeat (3 * LEN - 1) step(1, 0, 0, 1, 32767, -32768);
    repeat (ML + 2) step(1, 0, 0, 0, 32767, -32768);
    chk("cont_pulses", vq.size(), 3);
    for (int i = 1; i < vq.size(); i++) chk("cont_gap", vq[i] - vq[i-1], LEN);
    chk("cont_re", int'(re_o), 32767);

    // Stop after two samples, then a fresh full window of 100
    vq.delete();
    step(1, 1, 0, 0, 50, 0);
    repeat (2) step(1, 0, 0, 1, 50, 0);
    repeat (4) step(1, 0, 0, 0, 50, 0);
    step(1, 0, 1, 0, 50, 0);
    chk("stop_busy", int'(busy_o), 0);
    step(1, 1, 0, 0, 100, 0);
    repeat (LEN) step(1, 0, 0, 1, 100, 0);
    repeat (ML + 4) step(1, 0, 0, 0, 100, 0);
    chk("restart_pulses", vq.size(), 1);
    chk("restart_re", int'(re_o), 100);
    step(1, 1, 1, 0, 0, 0);
    chk("start_stop_busy", int'(busy_o), 0);

    // Reset mid-window with strobes in flight
    step(1, 1, 0, 0, 7, 7);
    repeat (LEN) step(1, 0, 0, 1, 7, 7);
    repeat (2) step(1, 0, 0, 0, 7, 7);
    step(0, 0, 0, 1, 7, 7);
    chk("rst_re", int'(re_o), 0);
    chk("rst_im", int'(im_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    vq.delete();
    repeat (8) step(1, 0, 0, 1, 7, 7);
    repeat (ML + 1) step(1, 0, 0, 0, 7, 7);
    chk("rst_no_pulse", vq.size(), 0);
    step(1, 1, 0, 0, 7, 7);
    repeat (LEN) step(1, 0, 0, 1, 7, 7);
    repeat (ML + 2) step(1, 0, 0, 0, 7, 7);
    chk("rst_new_pulses", vq.size(), 1);
    chk("rst_new_re", int'(re_o), 7);

    // Randomized traffic against the reference model
    for (int n = 0; n < 1500; n++) begin
      r  = int'($urandom_range(0, 999));
      rs = (r >= 3);
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 79) == 0);
      iv = ($urandom_range(0, 3) != 0);
      step(rs, st, sp, iv, int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
